poly_inverse_solver: RTL and testbench
======================================

# poly_inverse_solver

Iterative inverse of the quadratic evaluator. Given unsigned coefficients A, B, C and a target y, it finds the largest unsigned x such that f(x) = A·x² + B·x + C ≤ y. It uses bit-serial bisection over a single shared multiply-accumulate datapath under a small control FSM. It sits beside the polynomial evaluator and uses the same start/done style (inicio/pronto), so the evaluator's output can be fed back and checked for consistency.

## Interface
Parameters:
- W, default 16: width of A, B, C, y and x.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- inicio  input  1  start request; sampled only in IDLE.
- A, B, C  input  W each  unsigned coefficients.
- y  input  W  unsigned target.
- x  output  W  result: largest x with f(x) ≤ y.
- encontrado  output  1  high when a solution exists (C ≤ y).
- exato  output  1  high when f(x) == y.
- ocupado  output  1  high in every state except IDLE.
- pronto  output  1  one-cycle completion pulse.

## Operation
- Monotonicity: unsigned coefficients make f non-decreasing, so bisection is exact.
- Internal accumulator t is 3W+2 bits, so f never overflows.
- States: IDLE, MUL1, MUL2, CMP, DONE.
- IDLE:
  - On inicio=1, capture A, B, C, y into internal registers.
  - Clear x_q and exato.
  - Set encontrado = (C ≤ y), bit = W-1, cand = 1<<(W-1).
  - Go to MUL1.
- MUL1: t ← A·cand + B.
- MUL2: t ← t·cand + C.
- CMP:
  - If t ≤ y: x_q ← cand and exato ← (t == y).
  - If bit == 0, go to DONE.
  - Otherwise: bit ← bit-1, cand ← x_q_new | (1<<(bit-1)), go to MUL1.
- DONE: assert pronto for one cycle, then go to IDLE.
- If C > y, no candidate is ever accepted. Result: x=0, encontrado=0, exato=0.
- If f(0)=C==y with no larger match, exato must read 1. Set exato ← (C==y) at capture; CMP overwrites it only on acceptance.
- x, encontrado and exato hold their values from DONE until the next accepted inicio.
- Inputs may change after the capture edge without effect.

## Timing
- Reset values: state=IDLE; x=0, encontrado=0, exato=0, ocupado=0, pronto=0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately. No pronto is issued for the aborted run.
- Start: inicio is sampled on edge E0. ocupado is high from E0 onward.
- Latency: 3 cycles per bit.
  - The last CMP occurs at edge E0+3W-1, so DONE is entered at E0+3W.
  - pronto is high for exactly one cycle after E0+3W (E0+48 for W=16).
- ocupado falls on the edge that leaves DONE.
- inicio is ignored while ocupado=1. No queueing.
- inicio held high continuously: a new run starts on the edge after DONE (back-to-back runs with one IDLE cycle).

## Configuration
- EARLY_EXIT_EN defined:
  - In CMP, if t == y, set x_q ← cand and exato=1, and go to DONE immediately.
  - Latency becomes variable, at most 3W.
  - x is the first exact match found, which is not necessarily the largest (only relevant when f is flat).
- EARLY_EXIT_EN undefined: fixed 3W latency and the largest-x result as above.

## Test plan
- Nominal: A=1, B=1, C=2, y=8, W=16.
  - Without the macro: pronto at E0+48, x=2, exato=1, encontrado=1.
  - With EARLY_EXIT_EN: pronto at E0+45, x=2.
- Inexact: A=1, B=1, C=2, y=9 → x=2, exato=0, encontrado=1.
- No solution: A=3, B=0, C=5, y=3 → x=0, encontrado=0, exato=0, pronto still at E0+48.
- Flat and extreme: A=B=C=0, y=0 → x=65535, exato=1. Separately, A=B=C=65535, y=65535 → x=0, exato=1, with no overflow.
- Reset mid-run: pulse rst low at E0+20 → outputs at reset values and no pronto. A subsequent start with A=0, B=2, C=0, y=10 → x=5, exato=1.
- Busy protection: toggle inicio with different operands at E0+10 → ignored. Holding inicio high → second run's pronto exactly 3W+2 edges after the first pronto.

Source files
------------

// File: rtl/poly_inverse_solver_if.sv
// poly_inverse_solver_if: start/done handshake and operand bus of the
// quadratic inverse solver. master = requester, slave = solver.
interface poly_inverse_solver_if #(
  parameter int W = 16
);
  logic         inicio;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic [W-1:0] y;
  logic [W-1:0] x;
  logic         encontrado;
  logic         exato;
  logic         ocupado;
  logic         pronto;

  modport master (
    output inicio, A, B, C, y,
    input  x, encontrado, exato, ocupado, pronto
  );

  modport slave (
    input  inicio, A, B, C, y,
    output x, encontrado, exato, ocupado, pronto
  );
endinterface

// File: rtl/poly_inverse_solver.sv
// poly_inverse_solver: finds the largest unsigned x with A*x^2 + B*x + C <= y
// by MSB-first bisection. One shared multiply-accumulate evaluates f(cand)
// in Horner form over two cycles (MUL1, MUL2), CMP accepts or rejects the
// candidate bit. Fixed latency of 3 cycles per bit.
//
// Optional build macro EARLY_EXIT_EN: finish as soon as CMP sees f(cand)==y
// (variable latency, first exact match rather than largest).
//
// state | meaning
// IDLE  | waiting for inicio; operands captured on acceptance
// MUL1  | t <- A*cand + B
// MUL2  | t <- t*cand + C
// CMP   | accept cand if t <= y; next bit or finish
// DONE  | one-cycle pronto; results held afterwards
module poly_inverse_solver #(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  poly_inverse_solver_if.slave bus
);

  localparam int TW = 3 * W + 2;
  localparam int BW = (W > 2) ? $clog2(W) : 1;
  localparam logic [BW-1:0] BIT_ONE = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_MUL2 = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   c_q, c_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   cand_q, cand_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [TW-1:0]  t_q, t_d;
  logic           enc_q, enc_d;
  logic           exato_q, exato_d;

  logic [TW-1:0]  mac_op;
  logic [TW-1:0]  mac_add;
  logic [TW-1:0]  mac;
  logic [TW-1:0]  y_ext;
  logic           accept;
  logic [W-1:0]   x_new;

  // Shared Horner MAC: A*cand+B in MUL1, t*cand+C in MUL2; width TW never overflows
  always_comb begin
    mac_op  = (state_q == S_MUL1) ? {{(TW-W){1'b0}}, a_q} : t_q;
    mac_add = (state_q == S_MUL1) ? {{(TW-W){1'b0}}, b_q} : {{(TW-W){1'b0}}, c_q};
    mac     = mac_op * {{(TW-W){1'b0}}, cand_q} + mac_add;
    y_ext   = {{(TW-W){1'b0}}, y_q};
    accept  = (t_q <= y_ext);
    x_new   = accept ? cand_q : x_q;
  end

  // Next-state, datapath updates and bisection control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    y_d     = y_q;
    x_d     = x_q;
    cand_d  = cand_q;
    bit_d   = bit_q;
    t_d     = t_q;
    enc_d   = enc_q;
    exato_d = exato_q;

    case (state_q)
      S_IDLE: begin
        if (bus.inicio) begin
          a_d     = bus.A;
          b_d     = bus.B;
          c_d     = bus.C;
          y_d     = bus.y;
          x_d     = '0;
          // f(0)=C: covers the case where x=0 is itself an exact hit
          exato_d = (bus.C == bus.y);
          enc_d   = (bus.C <= bus.y);
          bit_d   = BW'(W - 1);
          cand_d  = ONE_W << (W - 1);
          state_d = S_MUL1;
        end
      end
      S_MUL1: begin
        t_d     = mac;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        t_d     = mac;
        state_d = S_CMP;
      end
      S_CMP: begin
`ifdef EARLY_EXIT_EN
        if (t_q == y_ext) begin
          x_d     = cand_q;
          exato_d = 1'b1;
          state_d = S_DONE;
        end else begin
`endif
          if (accept) begin
            x_d     = cand_q;
            exato_d = (t_q == y_ext);
          end
          if (bit_q == '0) begin
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q - BIT_ONE;
            cand_d  = x_new | (ONE_W << (bit_q - BIT_ONE));
            state_d = S_MUL1;
          end
`ifdef EARLY_EXIT_EN
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async active-low reset aborts any run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      y_q     <= '0;
      x_q     <= '0;
      cand_q  <= '0;
      bit_q   <= '0;
      t_q     <= '0;
      enc_q   <= 1'b0;
      exato_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      y_q     <= y_d;
      x_q     <= x_d;
      cand_q  <= cand_d;
      bit_q   <= bit_d;
      t_q     <= t_d;
      enc_q   <= enc_d;
      exato_q <= exato_d;
    end
  end

  // Outputs decode directly from registered state
  always_comb begin
    bus.x          = x_q;
    bus.encontrado = enc_q;
    bus.exato      = exato_q;
    bus.ocupado    = (state_q != S_IDLE);
    bus.pronto     = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_poly_inverse_solver.sv
// tb_poly_inverse_solver: directed vectors for poly_inverse_solver (W=16)
module tb_poly_inverse_solver;

  localparam int W = 16;
`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   lat;

  poly_inverse_solver_if #(.W(W)) bus ();

  poly_inverse_solver #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Start a run from IDLE, return edges from E0 until pronto is seen (200 = timeout)
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [15:0] yy, input bit glitch, output int n);
    bus.A = a; bus.B = b; bus.C = c; bus.y = yy;
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    chk("ocupado_after_e0", bus.ocupado, 1);
    if (glitch) begin
      bus.A = 16'h1234; bus.B = 16'd7; bus.C = 16'd0; bus.y = 16'hFFFF;
    end
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (glitch && n == 10) bus.inicio = 1'b1;
      if (glitch && n == 11) bus.inicio = 1'b0;
      if (bus.pronto) break;
    end
    if (!bus.pronto) begin
      chk("timeout", 0, 1);
      n = 200;
    end
  endtask

  // Check the cycle after pronto: back in IDLE, pronto gone
  task automatic after_done(input string tag);
    @(posedge clk); #1;
    chk({tag, "_pronto_1cyc"}, bus.pronto, 0);
    chk({tag, "_idle"}, bus.ocupado, 0);
  endtask

  initial begin
    int  n2;
    bit  seen;
    n_checks = 0;
    n_fail   = 0;
    bus.inicio = 1'b0;
    bus.A = '0; bus.B = '0; bus.C = '0; bus.y = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", bus.x, 0);
    chk("rst_enc", bus.encontrado, 0);
    chk("rst_exato", bus.exato, 0);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_pronto", bus.pronto, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Nominal: f(2)=8
    run(16'd1, 16'd1, 16'd2, 16'd8, 1'b0, lat);
    chk("nom_lat", lat, EE ? 45 : 48);
    chk("nom_x", bus.x, 2);
    chk("nom_exato", bus.exato, 1);
    chk("nom_enc", bus.encontrado, 1);
    after_done("nom");
    repeat (3) @(posedge clk);
    #1;
    chk("nom_hold_x", bus.x, 2);
    chk("nom_hold_exato", bus.exato, 1);

    // Inexact: f(2)=8 <= 9 < f(3)=14
    run(16'd1, 16'd1, 16'd2, 16'd9, 1'b0, lat);
    chk("inex_lat", lat, 48);
    chk("inex_x", bus.x, 2);
    chk("inex_exato", bus.exato, 0);
    chk("inex_enc", bus.encontrado, 1);
    after_done("inex");

    // No solution: C=5 > y=3
    run(16'd3, 16'd0, 16'd5, 16'd3, 1'b0, lat);
    chk("none_lat", lat, 48);
    chk("none_x", bus.x, 0);
    chk("none_enc", bus.encontrado, 0);
    chk("none_exato", bus.exato, 0);
    after_done("none");

    // Flat f=0, y=0: every candidate exact
    run(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, lat);
    chk("flat_lat", lat, EE ? 3 : 48);
    chk("flat_x", bus.x, EE ? 32768 : 65535);
    chk("flat_exato", bus.exato, 1);
    after_done("flat");

    // Extreme coefficients: only x=0 fits, f(0)==y
    run(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, lat);
    chk("ext_lat", lat, 48);
    chk("ext_x", bus.x, 0);
    chk("ext_exato", bus.exato, 1);
    chk("ext_enc", bus.encontrado, 1);
    after_done("ext");

    // Reset mid-run at E0+20
    bus.A = 16'd1; bus.B = 16'd1; bus.C = 16'd2; bus.y = 16'd8;
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_busy_before", bus.ocupado, 1);
    rst = 1'b0;
    #1;
    chk("abort_x", bus.x, 0);
    chk("abort_enc", bus.encontrado, 0);
    chk("abort_exato", bus.exato, 0);
    chk("abort_ocupado", bus.ocupado, 0);
    chk("abort_pronto", bus.pronto, 0);
    #2;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.pronto || bus.ocupado) seen = 1'b1;
    end
    chk("abort_no_pronto", seen, 0);

    // Fresh run after abort: 2x <= 10
    run(16'd0, 16'd2, 16'd0, 16'd10, 1'b0, lat);
    chk("post_lat", lat, 48);
    chk("post_x", bus.x, 5);
    chk("post_exato", bus.exato, 1);
    after_done("post");

    // Busy protection: operands change after E0, inicio pulsed at E0+10
    run(16'd1, 16'd1, 16'd2, 16'd9, 1'b1, lat);
    chk("busy_lat", lat, 48);
    chk("busy_x", bus.x, 2);
    chk("busy_exato", bus.exato, 0);
    after_done("busy");

    // Held inicio: back-to-back runs, second pronto 3W+2 edges after the first
    bus.A = 16'd0; bus.B = 16'd2; bus.C = 16'd0; bus.y = 16'd10;
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (bus.pronto) break;
    end
    chk("held_lat1", lat, 48);
    n2 = 0;
    while (n2 < 200) begin
      @(posedge clk); #1;
      n2++;
      if (bus.pronto) break;
    end
    chk("held_gap", n2, 3 * W + 2);
    chk("held_x", bus.x, 5);
    bus.inicio = 1'b0;
    after_done("held");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
